// File: rtl/data_mem_resp_mod.sv
// Word-addressed data-memory responder for the multi-cycle core.
// It accepts one load/store at a time, waits a programmable number of
// cycles, and then performs the access. Completion is a single-cycle
// ready pulse. A rejected request raises a sticky fault for the halt logic.
`timescale 1ns/1ps

module data_mem_resp_mod #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              fault_o
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;

    // The word index is compared against the depth at its full width, so
    // high address bits can never alias back into the legal range.
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

    // The wait counter starts at LATENCY-1. The LATENCY=0 build never loads it.
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                fault_q;

    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    // The single RAM port is shared between the accept edge (LATENCY=0) and WAIT.
    logic                mem_we;
    logic                mem_re;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_wdata;

    // The request is decoded straight from the bus, because it must be
    // classified at the accept edge.
    logic                req_misaligned;
    logic                req_out_of_range;
    logic                req_err;
    logic [IDX_W-1:0]    req_idx;
    logic                accept;

    assign req_misaligned   = (addr_i[1:0] != 2'b00);
    assign req_out_of_range = (addr_i[ADDR_W-1:2] >= DEPTH_LIM);
    assign req_err          = req_misaligned | req_out_of_range;
    assign req_idx          = addr_i[IDX_W+1:2];
    assign accept           = (state_q == ST_IDLE) && req_i;

    // Next-state, wait counter and RAM port control.
    // NOTE: every signal gets a default value first, so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (LATENCY == 0) begin
                        state_d   = ST_RESP;
                        mem_we    = we_i;
                        mem_re    = ~we_i;
                        mem_idx   = req_idx;
                        mem_wdata = wdata_i;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    mem_we  = we_q;
                    mem_re  = ~we_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter.
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request so the requester can drop its signals after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= we_i;
            idx_q   <= req_idx;
            wdata_q <= wdata_i;
            err_q   <= req_err;
        end
    end

    // Sticky fault. It is set on the edge that rejects a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (accept && req_err) begin
            fault_q <= 1'b1;
        end
    end

    // Read-data register. It changes only on a successful read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= mem[mem_idx];
        end
    end

    // Storage array with a single write port.
    // NOTE: the storage has no reset, so it maps onto a RAM macro. A write aborted by reset never fires because the state register is already IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign ready_o = (state_q == ST_RESP);
    assign err_o   = (state_q == ST_RESP) && err_q;
    assign rdata_o = rdata_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_data_mem_resp_mod.sv
// Bench for data_mem_resp_mod: a LATENCY=2 instance driven through a
// scoreboard, plus a LATENCY=0 instance used for the zero-wait build.
`timescale 1ns/1ps

module tb_data_mem_resp_mod;

    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, ready_o, err_o, fault_o;
    logic [31:0] rdata_o;

    logic        req0 = 1'b0;
    logic        we0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic        busy0, ready0, err0, fault0;
    logic [31:0] rdata0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] model_rdata = '0;
    logic        model_fault = 1'b0;

    vec_t        vecs [11];

    data_mem_resp_mod #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .ready_o(ready_o), .err_o(err_o),
        .rdata_o(rdata_o), .fault_o(fault_o)
    );

    data_mem_resp_mod #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .busy_o(busy0), .ready_o(ready0), .err_o(err0),
        .rdata_o(rdata0), .fault_o(fault0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ready_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_err", 32'(err_o), 32'(mon_e.err));
                check("resp_rdata", rdata_o, mon_e.rdata);
                check("resp_fault", 32'(fault_o), 32'(mon_e.fault));
                check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic wait_drain(input string name);
        int budget = 0;
        while (sb.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check(name, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Issue one request and build its expected response from the bench model.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err);
        exp_t e;
        int   budget = 0;
        while (busy_o && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
        if (exp_err) begin
            model_fault = 1'b1;
        end else if (we) begin
            model_mem[addr[31:2]] = wdata;
        end else begin
            model_rdata = model_mem[addr[31:2]];
        end
        e.err   = exp_err;
        e.rdata = model_rdata;
        e.fault = model_fault;
        e.cyc   = exp_err ? cyc + 1 : cyc + LAT + 1;
        sb.push_back(e);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        @(negedge clk);
        req_i   = 1'b0;
        wdata_i = '0;
        wait_drain("resp_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h0000_0001, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0022, 32'h0,         1'b1};
        vecs[10] = '{1'b1, 32'h8000_0010, 32'h5555_AAAA, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_ready0", 32'(ready0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven requests.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err);
            @(negedge clk);
        end

        // Hold req_i high: the design accepts one request every LAT+2 cycles.
        n = cyc;
        model_rdata = model_mem[30'h4];
        for (int k = 0; k < 3; k++) begin
            e.err = 1'b0; e.rdata = model_rdata; e.fault = model_fault;
            e.cyc = n + LAT + 1 + k * (LAT + 2);
            sb.push_back(e);
        end
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
        for (int k = 0; k < 12; k++) begin
            check("hold_busy", 32'(busy_o), 32'((k % 4) != 0));
            @(negedge clk);
        end
        req_i = 1'b0;
        wait_drain("hold_timeout");
        @(negedge clk);

        // A req_i pulse during WAIT must not create a second response.
        n = cyc;
        model_rdata = model_mem[30'hFF];
        e.err = 1'b0; e.rdata = model_rdata; e.fault = model_fault; e.cyc = n + LAT + 1;
        sb.push_back(e);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h3FC;
        @(negedge clk);
        req_i = 1'b0;
        check("wait_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        req_i = 1'b1; addr_i = 32'h10;
        @(negedge clk);
        req_i = 1'b0;
        repeat (6) @(negedge clk);
        check("wait_pulse_idle", 32'(busy_o), 32'd0);
        wait_drain("wait_pulse_timeout");

        // Reset during WAIT discards the pending write and clears the fault.
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678;
        @(negedge clk);
        req_i = 1'b0;
        check("midrst_busy_before", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        check("midrst_rdata", rdata_o, 32'd0);
        check("midrst_fault", 32'(fault_o), 32'd0);
        model_rdata = '0;
        model_fault = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_ready", 32'(busy_o), 32'd0);
        issue(1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);

        // LATENCY=0 build: the access happens at the accept edge and ready follows one cycle later.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'hA5A5_A5A5;
        @(negedge clk);
        req0 = 1'b0;
        check("lat0_wr_ready", 32'(ready0), 32'd1);
        check("lat0_wr_err", 32'(err0), 32'd0);
        check("lat0_wr_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        check("lat0_idle", 32'(ready0), 32'd0);
        req0 = 1'b1; we0 = 1'b0;
        @(negedge clk);
        req0 = 1'b0;
        check("lat0_rd_ready", 32'(ready0), 32'd1);
        check("lat0_rd_rdata", rdata0, 32'hA5A5_A5A5);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h2;
        @(negedge clk);
        req0 = 1'b0;
        check("lat0_err", 32'(err0), 32'd1);
        check("lat0_err_rdata", rdata0, 32'hA5A5_A5A5);
        check("lat0_fault", 32'(fault0), 32'd1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
